sid_reg_ctrl: RTL

//  CPU-side register controller for the SID: decodes bus accesses to the 29-byte register
//  map, holds per-voice configuration (fcw/pw/control/ADSR) for three sid_voice instances,

---
 rtl/sid_pkg.sv | 29 ++
 rtl/sid_reg_ctrl_if.sv | 15 +
 rtl/sid_voice_regs.sv | 89 ++++++++
 rtl/sid_reg_ctrl.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/sid_pkg.sv
// Shared definitions for the SID register controller: register map addresses, voice bank
// geometry and the default bus-latch decay length.
package sid_pkg;

  // Per-voice register offsets, relative to the voice base address.
  localparam logic [4:0] SID_FREQ_LO  = 5'h00;
  localparam logic [4:0] SID_FREQ_HI  = 5'h01;
  localparam logic [4:0] SID_PW_LO    = 5'h02;
  localparam logic [4:0] SID_PW_HI    = 5'h03;
  localparam logic [4:0] SID_CTRL     = 5'h04;
  localparam logic [4:0] SID_AD       = 5'h05;
  localparam logic [4:0] SID_SR       = 5'h06;

  // Global registers.
  localparam logic [4:0] SID_FC_LO    = 5'h15;
  localparam logic [4:0] SID_FC_HI    = 5'h16;
  localparam logic [4:0] SID_RES_FILT = 5'h17;
  localparam logic [4:0] SID_MODE_VOL = 5'h18;
  localparam logic [4:0] SID_POTX     = 5'h19;
  localparam logic [4:0] SID_POTY     = 5'h1A;
  localparam logic [4:0] SID_OSC3     = 5'h1B;
  localparam logic [4:0] SID_ENV3     = 5'h1C;

  localparam int unsigned VOICE_STRIDE = 7;
  localparam int unsigned NUM_VOICES   = 3;

  localparam logic [23:0] DECAY_CYCLES_DEF = 24'd2000;

endpackage

// File: rtl/sid_reg_ctrl_if.sv
// CPU bus port of the SID register controller.
//   bus_en : 1 MHz phi2 strobe      cs   : chip select
//   we     : 1=write, 0=read        addr : register address
//   din    : write data             dout : registered read data
interface sid_reg_ctrl_if;
  logic       bus_en;
  logic       cs;
  logic       we;
  logic [4:0] addr;
  logic [7:0] din;
  logic [7:0] dout;

  modport master (output bus_en, output cs, output we, output addr, output din, input dout);
  modport slave  (input bus_en, input cs, input we, input addr, input din, output dout);
endinterface

// File: rtl/sid_voice_regs.sv
// Seven-byte register bank for one SID voice plus gate edge strobes.
//   clk, reset           : clock, synchronous active-high reset
//   wr_i, addr_i, din_i  : qualified write access (bus_en & cs & we), address, data
//   fcw_o, pw_o, ctrl_o, ad_o, sr_o : raw register contents
//   gate_on_o/gate_off_o : one-cycle strobes, coincident with the ctrl update that flips gate
module sid_voice_regs
  import sid_pkg::*;
#(
  parameter logic [4:0] BASE = 5'h00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_i,
  input  logic [4:0]  addr_i,
  input  logic [7:0]  din_i,
  output logic [15:0] fcw_o,
  output logic [11:0] pw_o,
  output logic [7:0]  ctrl_o,
  output logic [7:0]  ad_o,
  output logic [7:0]  sr_o,
  output logic        gate_on_o,
  output logic        gate_off_o
);

  logic [15:0] fcw_q, fcw_d;
  logic [11:0] pw_q, pw_d;
  logic [7:0]  ctrl_q, ctrl_d, ad_q, ad_d, sr_q, sr_d;
  logic        gate_on_q, gate_on_d, gate_off_q, gate_off_d;
  logic        hit;
  logic [4:0]  off;

  assign hit = (addr_i >= BASE) && (addr_i < BASE + 5'(VOICE_STRIDE));
  assign off = addr_i - BASE;

  always_comb begin
    fcw_d      = fcw_q;
    pw_d       = pw_q;
    ctrl_d     = ctrl_q;
    ad_d       = ad_q;
    sr_d       = sr_q;
    gate_on_d  = 1'b0;
    gate_off_d = 1'b0;
    if (wr_i && hit) begin
      case (off)
        SID_FREQ_LO: fcw_d[7:0]  = din_i;
        SID_FREQ_HI: fcw_d[15:8] = din_i;
        SID_PW_LO:   pw_d[7:0]   = din_i;
        SID_PW_HI:   pw_d[11:8]  = din_i[3:0];
        SID_CTRL: begin
          ctrl_d     = din_i;
          gate_on_d  = din_i[0] & ~ctrl_q[0];
          gate_off_d = ~din_i[0] & ctrl_q[0];
        end
        SID_AD:      ad_d        = din_i;
        SID_SR:      sr_d        = din_i;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fcw_q      <= '0;
      pw_q       <= '0;
      ctrl_q     <= '0;
      ad_q       <= '0;
      sr_q       <= '0;
      gate_on_q  <= 1'b0;
      gate_off_q <= 1'b0;
    end else begin
      fcw_q      <= fcw_d;
      pw_q       <= pw_d;
      ctrl_q     <= ctrl_d;
      ad_q       <= ad_d;
      sr_q       <= sr_d;
      gate_on_q  <= gate_on_d;
      gate_off_q <= gate_off_d;
    end
  end

  assign fcw_o      = fcw_q;
  assign pw_o       = pw_q;
  assign ctrl_o     = ctrl_q;
  assign ad_o       = ad_q;
  assign sr_o       = sr_q;
  assign gate_on_o  = gate_on_q;
  assign gate_off_o = gate_off_q;

endmodule

// File: rtl/sid_reg_ctrl.sv
// SID CPU-side register controller: decodes bus accesses, holds voice/filter registers,
// and provides the read path (POT/OSC3/ENV3, else a decaying copy of the last written byte).
//   clk, reset         : clock, synchronous active-high reset
//   bus                : CPU bus (bus_en, cs, we, addr, din in; dout out)
//   osc3, env3         : voice 3 oscillator/envelope readback
//   potx, poty         : paddle values
//   fcw*/pw*/ctrl*/ad*/sr* : per-voice registers; gate_on/gate_off : gate edge strobes
//   fc, res_filt, mode_vol : filter and volume registers
module sid_reg_ctrl
  import sid_pkg::*;
#(
  parameter logic [23:0] DECAY_CYCLES = DECAY_CYCLES_DEF
) (
  input  logic         clk,
  input  logic         reset,
  sid_reg_ctrl_if.slave bus,
  input  logic [7:0]   osc3,
  input  logic [7:0]   env3,
  input  logic [7:0]   potx,
  input  logic [7:0]   poty,
  output logic [15:0]  fcw0,
  output logic [15:0]  fcw1,
  output logic [15:0]  fcw2,
  output logic [11:0]  pw0,
  output logic [11:0]  pw1,
  output logic [11:0]  pw2,
  output logic [7:0]   ctrl0,
  output logic [7:0]   ctrl1,
  output logic [7:0]   ctrl2,
  output logic [7:0]   ad0,
  output logic [7:0]   ad1,
  output logic [7:0]   ad2,
  output logic [7:0]   sr0,
  output logic [7:0]   sr1,
  output logic [7:0]   sr2,
  output logic [2:0]   gate_on,
  output logic [2:0]   gate_off,
  output logic [10:0]  fc,
  output logic [7:0]   res_filt,
  output logic [7:0]   mode_vol
);

  logic        wr, rd;
  logic [10:0] fc_q, fc_d;
  logic [7:0]  res_filt_q, res_filt_d, mode_vol_q, mode_vol_d;
  logic [7:0]  latch_q, latch_d, dout_q, dout_d;
  logic [23:0] cnt_q, cnt_d;

  logic [15:0] fcw_v  [NUM_VOICES];
  logic [11:0] pw_v   [NUM_VOICES];
  logic [7:0]  ctrl_v [NUM_VOICES];
  logic [7:0]  ad_v   [NUM_VOICES];
  logic [7:0]  sr_v   [NUM_VOICES];

  assign wr = bus.bus_en & bus.cs & bus.we;
  assign rd = bus.bus_en & bus.cs & ~bus.we;

  for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
    sid_voice_regs #(
      .BASE(5'(v * VOICE_STRIDE))
    ) u_voice (
      .clk       (clk),
      .reset     (reset),
      .wr_i      (wr),
      .addr_i    (bus.addr),
      .din_i     (bus.din),
      .fcw_o     (fcw_v[v]),
      .pw_o      (pw_v[v]),
      .ctrl_o    (ctrl_v[v]),
      .ad_o      (ad_v[v]),
      .sr_o      (sr_v[v]),
      .gate_on_o (gate_on[v]),
      .gate_off_o(gate_off[v])
    );
  end

  always_comb begin
    fc_d       = fc_q;
    res_filt_d = res_filt_q;
    mode_vol_d = mode_vol_q;
    latch_d    = latch_q;
    cnt_d      = cnt_q;
    dout_d     = dout_q;

    if (wr) begin
      case (bus.addr)
        SID_FC_LO:    fc_d[2:0]  = bus.din[2:0];
        SID_FC_HI:    fc_d[10:3] = bus.din;
        SID_RES_FILT: res_filt_d = bus.din;
        SID_MODE_VOL: mode_vol_d = bus.din;
        default: ;
      endcase
    end

    // A write always wins over decay, even when the counter has saturated.
    if (wr) begin
      latch_d = bus.din;
      cnt_d   = '0;
    end else if (bus.bus_en && (cnt_q != DECAY_CYCLES)) begin
      cnt_d = cnt_q + 24'd1;
      if (cnt_d == DECAY_CYCLES) latch_d = '0;
    end

    if (rd) begin
      case (bus.addr)
        SID_POTX: dout_d = potx;
        SID_POTY: dout_d = poty;
        SID_OSC3: dout_d = osc3;
        SID_ENV3: dout_d = env3;
        default:  dout_d = latch_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fc_q       <= '0;
      res_filt_q <= '0;
      mode_vol_q <= '0;
      latch_q    <= '0;
      cnt_q      <= '0;
      dout_q     <= '0;
    end else begin
      fc_q       <= fc_d;
      res_filt_q <= res_filt_d;
      mode_vol_q <= mode_vol_d;
      latch_q    <= latch_d;
      cnt_q      <= cnt_d;
      dout_q     <= dout_d;
    end
  end

  assign bus.dout = dout_q;
  assign fc       = fc_q;
  assign res_filt = res_filt_q;
  assign mode_vol = mode_vol_q;

  assign fcw0 = fcw_v[0];
  assign fcw1 = fcw_v[1];
  assign fcw2 = fcw_v[2];
  assign pw0  = pw_v[0];
  assign pw1  = pw_v[1];
  assign pw2  = pw_v[2];
  assign ctrl0 = ctrl_v[0];
  assign ctrl1 = ctrl_v[1];
  assign ctrl2 = ctrl_v[2];
  assign ad0  = ad_v[0];
  assign ad1  = ad_v[1];
  assign ad2  = ad_v[2];
  assign sr0  = sr_v[0];
  assign sr1  = sr_v[1];
  assign sr2  = sr_v[2];

endmodule
